task_sequencer: RTL and testbench

Parametrised post-detection task sequencer, next generation of the single-pair servo state machine. When the ultrasonic stop signal is seen, it runs up to NUM_TASKS actuator tasks (arm, marble drop, future servos) one after another. Each task has a per-task mask and a watchdog timeout. Before it re-arms the ultrasonic path, it requires stop to stay low for a programmable time. It sits between the IPS/ultrasonic front end and the individual servo controllers.

---
 rtl/task_sequencer.sv | 162 ++++++++++++++++
 tb/tb_task_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/task_sequencer.sv
// Post-detection task sequencer: on ultrasonic stop, runs the masked actuator tasks in index order
// with a per-task watchdog, then waits for a quiet stop-low window before re-arming the front end.
module task_sequencer #(
  parameter int unsigned NUM_TASKS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned REARM_CYCLES   = 1000,
  parameter int unsigned IDXW           = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stop,
  input  logic [NUM_TASKS-1:0] task_mask,
  input  logic [NUM_TASKS-1:0] done,
  input  logic                 clear_fault,
  output logic [NUM_TASKS-1:0] enable,
  output logic [NUM_TASKS-1:0] task_reset,
  output logic                 IPS_using_US,
  output logic                 busy,
  output logic                 fault,
  output logic [IDXW-1:0]      fault_task
);

  localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > REARM_CYCLES) ? TIMEOUT_CYCLES
                                                                      : REARM_CYCLES;
  localparam int unsigned TW = $clog2(MaxCycles + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RearmLast   = TW'(REARM_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StRearm, StFault} state_e;

  state_e               state_q, state_d;
  logic [NUM_TASKS-1:0] mask_q, mask_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [TW-1:0]        timer_q, timer_d, timer_inc;
  logic [NUM_TASKS-1:0] enable_d, task_reset_d;
  logic                 ips_d, busy_d, fault_d;
  logic [IDXW-1:0]      fault_task_d;

  logic [IDXW-1:0]      first_idx, next_idx;
  logic                 next_found;

  // Lowest set bit of the incoming mask, and lowest latched task above the active one.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = int'(NUM_TASKS) - 1; i >= 0; i--) begin
      if (task_mask[i]) first_idx = IDXW'(i);
      if (mask_q[i] && (IDXW'(i) > idx_q)) begin
        next_idx   = IDXW'(i);
        next_found = 1'b1;
      end
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    enable_d     = enable;
    task_reset_d = task_reset;
    ips_d        = IPS_using_US;
    busy_d       = busy;
    fault_d      = fault;
    fault_task_d = fault_task;

    unique case (state_q)
      StIdle: begin
        if (stop) begin
          mask_d  = task_mask;
          timer_d = '0;
          if (|task_mask) begin
            state_d      = StRun;
            idx_d        = first_idx;
            enable_d     = NUM_TASKS'(1) << first_idx;
            task_reset_d = ~(NUM_TASKS'(1) << first_idx);
            busy_d       = 1'b1;
          end else begin
            state_d = StRearm;
            ips_d   = 1'b0;
          end
        end
      end
      StRun: begin
        // enable is one-hot on the active task, so this picks out done[idx_q] only.
        if (|(done & enable)) begin
          timer_d = '0;
          if (next_found) begin
            idx_d        = next_idx;
            enable_d     = NUM_TASKS'(1) << next_idx;
            task_reset_d = ~(NUM_TASKS'(1) << next_idx);
          end else begin
            state_d      = StRearm;
            enable_d     = '0;
            task_reset_d = '1;
            busy_d       = 1'b0;
            ips_d        = 1'b0;
          end
        end else if (timer_q == TimeoutLast) begin
          state_d      = StFault;
          enable_d     = '0;
          task_reset_d = '1;
          busy_d       = 1'b0;
          fault_d      = 1'b1;
          fault_task_d = idx_q;
          ips_d        = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StRearm: begin
        if (stop) begin
          timer_d = '0;
        end else if (timer_q == RearmLast) begin
          state_d = StIdle;
          timer_d = '0;
          ips_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      StFault: begin
        if (clear_fault) begin
          state_d = StRearm;
          fault_d = 1'b0;
          timer_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      enable       <= '0;
      task_reset   <= '1;
      IPS_using_US <= 1'b1;
      busy         <= 1'b0;
      fault        <= 1'b0;
      fault_task   <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      enable       <= enable_d;
      task_reset   <= task_reset_d;
      IPS_using_US <= ips_d;
      busy         <= busy_d;
      fault        <= fault_d;
      fault_task   <= fault_task_d;
    end
  end

endmodule

// File: tb/tb_task_sequencer.sv
// Scoreboard bench for task_sequencer: expected output vectors are queued as each stimulus
// cycle is driven and compared after the following clock edge.
module tb_task_sequencer;

  logic       clk;
  logic       reset;
  logic       stop;
  logic [1:0] task_mask;
  logic [1:0] done;
  logic       clear_fault;

  logic [1:0] en_a, tr_a, en_b, tr_b;
  logic       ips_a, busy_a, fault_a, ips_b, busy_b, fault_b;
  logic [2:0] ft_a, ft_b;

  // dut_a covers sequencing/rearm, dut_b (short watchdog) covers timeouts.
  task_sequencer #(
    .NUM_TASKS(2), .TIMEOUT_CYCLES(50), .REARM_CYCLES(4), .IDXW(3)
  ) dut_a (
    .clk(clk), .reset(reset), .stop(stop), .task_mask(task_mask), .done(done),
    .clear_fault(clear_fault), .enable(en_a), .task_reset(tr_a), .IPS_using_US(ips_a),
    .busy(busy_a), .fault(fault_a), .fault_task(ft_a)
  );

  task_sequencer #(
    .NUM_TASKS(2), .TIMEOUT_CYCLES(8), .REARM_CYCLES(4), .IDXW(3)
  ) dut_b (
    .clk(clk), .reset(reset), .stop(stop), .task_mask(task_mask), .done(done),
    .clear_fault(clear_fault), .enable(en_b), .task_reset(tr_b), .IPS_using_US(ips_b),
    .busy(busy_b), .fault(fault_b), .fault_task(ft_b)
  );

  logic [10:0] obs_a, obs_b;
  assign obs_a = {en_a, tr_a, ips_a, busy_a, fault_a, ft_a};
  assign obs_b = {en_b, tr_b, ips_b, busy_b, fault_b, ft_b};

  typedef struct {
    string       tag;
    logic        sel;
    logic [10:0] v;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] vec(input logic [1:0] en, input logic [1:0] tr,
                                      input logic ips, input logic bsy, input logic flt,
                                      input logic [2:0] ft);
    return {en, tr, ips, bsy, flt, ft};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_check();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, e.sel ? {21'd0, obs_b} : {21'd0, obs_a}, {21'd0, e.v});
    end
  endtask

  // Compare outputs now, without a clock edge.
  task automatic sample(input string tag, input logic sel, input logic [10:0] e);
    sb_q.push_back('{tag: tag, sel: sel, v: e});
    pop_check();
  endtask

  task automatic step(input string tag, input logic s, input logic [1:0] d, input logic c,
                      input logic sel, input logic [10:0] e);
    stop        = s;
    done        = d;
    clear_fault = c;
    sb_q.push_back('{tag: tag, sel: sel, v: e});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  logic [10:0] idle_v, run0_v, run1_v, rearm_v, fault1_v, rearm1_v, idle1_v;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    idle_v   = vec(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 3'd0);
    run0_v   = vec(2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 3'd0);
    run1_v   = vec(2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 3'd0);
    rearm_v  = vec(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 3'd0);
    fault1_v = vec(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 3'd1);
    rearm1_v = vec(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 3'd1);
    idle1_v  = vec(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 3'd1);

    reset = 1'b1; stop = 1'b0; task_mask = 2'b00; done = 2'b00; clear_fault = 1'b0;
    #1;
    sample("reset_a", 1'b0, idle_v);
    sample("reset_b", 1'b1, idle_v);
    #1 reset = 1'b0;
    step("idle_quiet", 1'b0, 2'b00, 1'b0, 1'b0, idle_v);

    // Full two-task sequence with gapless handover.
    task_mask = 2'b11;
    step("t1_start", 1'b1, 2'b00, 1'b0, 1'b0, run0_v);
    for (int i = 0; i < 9; i++) step("t1_run0", 1'b0, 2'b00, 1'b0, 1'b0, run0_v);
    step("t1_handover", 1'b0, 2'b01, 1'b0, 1'b0, run1_v);
    for (int i = 0; i < 4; i++) step("t1_run1", 1'b0, 2'b00, 1'b0, 1'b0, run1_v);
    step("t1_last_done", 1'b0, 2'b10, 1'b0, 1'b0, rearm_v);
    for (int i = 0; i < 3; i++) step("t1_rearm", 1'b0, 2'b00, 1'b0, 1'b0, rearm_v);
    step("t1_idle", 1'b0, 2'b00, 1'b0, 1'b0, idle_v);

    // Task 0 masked off; stop blip in REARM restarts the quiet window.
    task_mask = 2'b10;
    step("t2_start", 1'b1, 2'b00, 1'b0, 1'b0, run1_v);
    step("t2_done", 1'b0, 2'b10, 1'b0, 1'b0, rearm_v);
    for (int i = 0; i < 3; i++) step("t2_low3", 1'b0, 2'b00, 1'b0, 1'b0, rearm_v);
    step("t2_blip", 1'b1, 2'b00, 1'b0, 1'b0, rearm_v);
    for (int i = 0; i < 3; i++) step("t2_relow", 1'b0, 2'b00, 1'b0, 1'b0, rearm_v);
    step("t2_idle", 1'b0, 2'b00, 1'b0, 1'b0, idle_v);

    // Empty mask goes straight to REARM.
    task_mask = 2'b00;
    step("t3_stop", 1'b1, 2'b00, 1'b0, 1'b0, rearm_v);
    for (int i = 0; i < 3; i++) step("t3_rearm", 1'b0, 2'b00, 1'b0, 1'b0, rearm_v);
    step("t3_idle", 1'b0, 2'b00, 1'b0, 1'b0, idle_v);

    // Asynchronous reset while task 0 runs; done[0] during reset must be ignored.
    task_mask = 2'b11;
    step("t5_start", 1'b1, 2'b00, 1'b0, 1'b0, run0_v);
    step("t5_run0", 1'b0, 2'b00, 1'b0, 1'b0, run0_v);
    #2;
    reset = 1'b1; done = 2'b01; stop = 1'b1;
    #1;
    sample("t5_async_a", 1'b0, idle_v);
    sample("t5_async_b", 1'b1, idle_v);
    @(posedge clk);
    #1;
    sample("t5_hold", 1'b0, idle_v);
    #2;
    reset = 1'b0; stop = 1'b0; done = 2'b00;
    step("t5_resume", 1'b0, 2'b00, 1'b0, 1'b0, idle_v);

    // Watchdog on dut_b: done on the last allowed cycle wins, then task 1 times out.
    step("t4_start", 1'b1, 2'b00, 1'b0, 1'b1, run0_v);
    for (int i = 0; i < 7; i++) step("t4_run0", 1'b0, 2'b00, 1'b0, 1'b1, run0_v);
    step("t4_done_wins", 1'b0, 2'b01, 1'b0, 1'b1, run1_v);
    for (int i = 0; i < 7; i++) step("t4_run1", 1'b0, 2'b00, 1'b0, 1'b1, run1_v);
    step("t4_fault", 1'b0, 2'b00, 1'b0, 1'b1, fault1_v);
    for (int i = 0; i < 2; i++) step("t4_fault_hold", 1'b0, 2'b00, 1'b0, 1'b1, fault1_v);
    step("t4_clear", 1'b1, 2'b00, 1'b1, 1'b1, rearm1_v);
    for (int i = 0; i < 3; i++) step("t4_rearm", 1'b0, 2'b00, 1'b0, 1'b1, rearm1_v);
    step("t4_idle", 1'b0, 2'b00, 1'b0, 1'b1, idle1_v);

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
